// File: rtl/key_conditioner_if.sv
// -----------------------------------------------------------------------------
// key_conditioner_if
//   Bundles the raw push-button inputs and the conditioned key outputs of
//   key_conditioner into one port.
//   Signals (all N_KEYS wide, one bit per key channel):
//     key_n        raw buttons, active-low, asynchronous to clk
//     key_level    debounced level, 1 = pressed
//     key_press    one-cycle pulse on debounced press
//     key_release  one-cycle pulse on debounced release
//     key_hold     one-cycle pulse once a press has been held long enough
//     key_repeat   one-cycle auto-repeat strobes
//   Modports:
//     master  the side that owns the buttons and consumes the strobes
//     slave   the conditioner itself
// -----------------------------------------------------------------------------
interface key_conditioner_if #(
    parameter int N_KEYS = 4
) ();
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_hold;
    logic [N_KEYS-1:0] key_repeat;

    modport master (
        output key_n,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_hold,
        input  key_repeat
    );

    modport slave (
        input  key_n,
        output key_level,
        output key_press,
        output key_release,
        output key_hold,
        output key_repeat
    );
endinterface

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//   Turns raw, bouncing, active-low push-buttons into clean single-cycle
//   strobes. Every key channel is independent and runs:
//     2-flop synchronizer -> counter debounce -> press/release edge pulses
//     -> hold / auto-repeat state machine.
//   Every output is a flop; there is no combinational path from key_n.
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-high reset (assert async, release sync
//           by the surrounding reset logic)
//     bus   key_conditioner_if.slave: key_n in, key_level / key_press /
//           key_release / key_hold / key_repeat out
//   Parameters:
//     N_KEYS          number of key channels (must match the interface)
//     DEBOUNCE_COUNT  consecutive disagreeing samples needed to accept a change
//     HOLD_COUNT      cycles from the press edge to the key_hold pulse
//     REPEAT_COUNT    auto-repeat period once the hold pulse has fired
// -----------------------------------------------------------------------------
module key_conditioner #(
    parameter int N_KEYS         = 4,
    parameter int DEBOUNCE_COUNT = 500000,
    parameter int HOLD_COUNT     = 50000000,
    parameter int REPEAT_COUNT   = 12500000
) (
    input  logic             clk,
    input  logic             rst,
    key_conditioner_if.slave bus
);

    localparam int DW = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
    localparam int HW = (HOLD_COUNT > 1)     ? $clog2(HOLD_COUNT)     : 1;
    localparam int RW = (REPEAT_COUNT > 1)   ? $clog2(REPEAT_COUNT)   : 1;

    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_COUNT - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_COUNT - 1);
    localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_REPEAT
    } state_t;

    // Synchronizer
    logic [N_KEYS-1:0] s1_q, s1_d;
    logic [N_KEYS-1:0] s2_q, s2_d;

    // Debounce and edge pulses
    logic [N_KEYS-1:0] level_q,   level_d;
    logic [N_KEYS-1:0] press_q,   press_d;
    logic [N_KEYS-1:0] release_q, release_d;
    logic [DW-1:0]     dcnt_q [N_KEYS];
    logic [DW-1:0]     dcnt_d [N_KEYS];

    // Hold / repeat
    logic [N_KEYS-1:0] hold_q,    hold_d;
    logic [N_KEYS-1:0] repeat_q,  repeat_d;
    logic [HW-1:0]     hcnt_q [N_KEYS];
    logic [HW-1:0]     hcnt_d [N_KEYS];
    logic [RW-1:0]     rcnt_q [N_KEYS];
    logic [RW-1:0]     rcnt_d [N_KEYS];
    state_t            state_q [N_KEYS];
    state_t            state_d [N_KEYS];

    // Active-high synchronized sample and "change accepted this edge" flag
    logic [N_KEYS-1:0] sample;
    logic [N_KEYS-1:0] accept;

    assign sample = ~s2_q;

    always_comb begin
        s1_d      = bus.key_n;
        s2_d      = s1_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        hold_d    = '0;
        repeat_d  = '0;
        accept    = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            dcnt_d[i]  = dcnt_q[i];
            hcnt_d[i]  = hcnt_q[i];
            rcnt_d[i]  = rcnt_q[i];
            state_d[i] = state_q[i];

            // Debounce: a change is accepted only after DEBOUNCE_COUNT
            // consecutive disagreeing samples; any agreeing sample restarts.
            accept[i] = (sample[i] != level_q[i]) && (dcnt_q[i] == DCNT_LAST);
            if (sample[i] == level_q[i]) begin
                dcnt_d[i] = '0;
            end else if (accept[i]) begin
                level_d[i] = sample[i];
                dcnt_d[i]  = '0;
            end else begin
                dcnt_d[i] = dcnt_q[i] + DW'(1);
            end

            press_d[i]   = accept[i] &  sample[i];
            release_d[i] = accept[i] & ~sample[i];

            // Release wins over any hold/repeat event due on the same edge.
            if (release_d[i]) begin
                state_d[i] = ST_IDLE;
                hcnt_d[i]  = '0;
                rcnt_d[i]  = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (press_d[i]) begin
                            state_d[i]  = ST_HELD;
                            hcnt_d[i]   = '0;
                            repeat_d[i] = 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (hcnt_q[i] == HCNT_LAST) begin
                            state_d[i]  = ST_REPEAT;
                            hold_d[i]   = 1'b1;
                            repeat_d[i] = 1'b1;
                            hcnt_d[i]   = '0;
                            rcnt_d[i]   = '0;
                        end else begin
                            hcnt_d[i] = hcnt_q[i] + HW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (rcnt_q[i] == RCNT_LAST) begin
                            repeat_d[i] = 1'b1;
                            rcnt_d[i]   = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + RW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        hcnt_d[i]  = '0;
                        rcnt_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Synchronizer resets to "released" so reset never looks like a press.
            s1_q      <= '1;
            s2_q      <= '1;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            hold_q    <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                dcnt_q[i]  <= '0;
                hcnt_q[i]  <= '0;
                rcnt_q[i]  <= '0;
                state_q[i] <= ST_IDLE;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
            repeat_q  <= repeat_d;
            for (int i = 0; i < N_KEYS; i++) begin
                dcnt_q[i]  <= dcnt_d[i];
                hcnt_q[i]  <= hcnt_d[i];
                rcnt_q[i]  <= rcnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign bus.key_level   = level_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;
    assign bus.key_hold    = hold_q;
    assign bus.key_repeat  = repeat_q;

endmodule
